pipe_stage_buf: RTL

- Parametrised successor to the single-entry pipeline latches between stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Holds a WIDTH-bit packed stage bundle in a DEPTH-entry elastic buffer with a valid/ready handshake on both sides, plus synchronous flush.
- Downstream stalls are absorbed locally, so in_ready never depends combinationally on out_ready.
- Drop-in between any two pipeline stages; the stage packs and unpacks its own fields.

---
 rtl/pipe_stage_buf.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: DEPTH-entry FIFO with valid/ready on both sides and synchronous flush.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt / flush_cnt statistics outputs.
module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  count
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    localparam int PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_wp;
    logic [PTRW-1:0]  r_rp;
    logic [CNTW-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Handshake is derived from registered occupancy only, so in_ready never sees out_ready.
    assign w_full    = (r_count == CNTW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign out_data  = r_mem[r_rp];
    assign count     = r_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wp] <= in_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PTRW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PTRW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_flushCnt;
    logic        w_stallEvt;
    logic        w_flushEvt;

    assign w_stallEvt = out_valid && !out_ready;
    assign w_flushEvt = flush && !w_empty;
    assign stall_cnt  = r_stallCnt;
    assign flush_cnt  = r_flushCnt;

    // Statistics survive flush and stick at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stallEvt && (r_stallCnt != 32'hFFFF_FFFF)) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (w_flushEvt && (r_flushCnt != 32'hFFFF_FFFF)) begin
                r_flushCnt <= r_flushCnt + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    logic [PTRW-1:0] w_ptrDiff;
    assign w_ptrDiff = r_wp - r_rp;

    // When full the pointers coincide, so the modular difference only holds below DEPTH.
    always @(posedge CLK) begin
        if (nRST) begin
            assert (r_count <= CNTW'(DEPTH));
            assert (w_full || (r_count == CNTW'(w_ptrDiff)));
        end
    end
`endif

endmodule
